// File: rtl/pcg_acc_pkg.sv
// Shared state encoding, defaults and parameter checks for the pre-track read controller.
package pcg_acc_pkg;

  localparam int unsigned DEF_MAX_OUTSTANDING = 16;
  localparam int unsigned DEF_MISS_CNT_WIDTH  = 16;
  localparam int unsigned SPACING_W           = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ZERO = 3'd1,
    ST_PREFETCH  = 3'd2,
    ST_TRACK     = 3'd3,
    ST_DRAIN     = 3'd4
  } state_e;

  // Outstanding limit must be a power of two between 2 and 256.
  function automatic bit is_pow2_in_range(input int unsigned v);
    return (v >= 2) && (v <= 256) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/rd_credit_cnt.sv
// Saturating up/down counter of issued-but-unreturned reads, with full/empty flags.
module rd_credit_cnt #(
  parameter int unsigned MAX_CNT = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     inc_i,
  input  logic                     dec_i,
  output logic [$clog2(MAX_CNT):0] cnt_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned CW = $clog2(MAX_CNT) + 1;

  logic [CW-1:0] r_cnt;
  logic          w_inc;
  logic          w_dec;

  // Never count past the limit and never wrap below zero.
  assign w_inc = inc_i && (r_cnt != CW'(MAX_CNT));
  assign w_dec = dec_i && (r_cnt != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (w_inc && !w_dec) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (!w_inc && w_dec) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign cnt_o   = r_cnt;
  assign full_o  = (r_cnt == CW'(MAX_CNT));
  assign empty_o = (r_cnt == '0);

endmodule

// File: rtl/pre_track_rd_ctrl.sv
// Pre-track read controller: prefetches a spacing-deep window after the encoder
// zero pulse, then issues one read per laser sample while tracking.
module pre_track_rd_ctrl
  import pcg_acc_pkg::*;
#(
  parameter real         TCQ             = 0.1,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned MISS_CNT_WIDTH  = DEF_MISS_CNT_WIDTH
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [SPACING_W-1:0]             light_spot_spacing_i,
  input  logic                             laser_start_i,
  input  logic                             encode_zero_flag_i,
  input  logic                             laser_vld_i,
  input  logic                             pre_laser_rd_ready_i,
  input  logic                             pre_laser_rd_vld_i,
  output logic                             pre_laser_rd_seq_o,
  output logic                             second_track_en_o,
  output logic                             prefetch_done_o,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic [MISS_CNT_WIDTH-1:0]        miss_cnt_o,
  output logic                             busy_o
);

  // An illegal parameter set keeps the controller from ever issuing a read.
  localparam bit CFG_OK = is_pow2_in_range(MAX_OUTSTANDING) &&
                          (MISS_CNT_WIDTH >= 1) && (TCQ >= 0.0);

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic [SPACING_W-1:0]        r_pf_remain;
  logic [SPACING_W-1:0]        w_pf_remain_nxt;
  logic [MISS_CNT_WIDTH-1:0]   r_miss_cnt;
  logic [MISS_CNT_WIDTH-1:0]   w_miss_cnt_nxt;
  logic                        r_rd_seq;
  logic                        r_prefetch_done;
  logic                        w_prefetch_done_nxt;
  logic                        w_issue;
  logic                        w_can_issue;
  logic                        w_full;
  logic                        w_empty;

  assign w_can_issue = CFG_OK && laser_start_i && pre_laser_rd_ready_i && !w_full;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state         <= ST_IDLE;
      r_pf_remain     <= '0;
      r_miss_cnt      <= '0;
      r_rd_seq        <= 1'b0;
      r_prefetch_done <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_pf_remain     <= w_pf_remain_nxt;
      r_miss_cnt      <= w_miss_cnt_nxt;
      r_rd_seq        <= w_issue;
      r_prefetch_done <= w_prefetch_done_nxt;
    end
  end

  // Dropping laser_start_i from any active state goes straight to DRAIN.
  always_comb begin
    w_state_nxt         = r_state;
    w_pf_remain_nxt     = r_pf_remain;
    w_miss_cnt_nxt      = r_miss_cnt;
    w_issue             = 1'b0;
    w_prefetch_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (laser_start_i) begin
          w_state_nxt    = ST_WAIT_ZERO;
          w_miss_cnt_nxt = '0;
        end
      end
      ST_WAIT_ZERO: begin
        if (!laser_start_i) begin
          w_state_nxt = ST_DRAIN;
        end else if (encode_zero_flag_i) begin
          w_pf_remain_nxt = light_spot_spacing_i;
          if (light_spot_spacing_i == '0) begin
            w_state_nxt         = ST_TRACK;
            w_prefetch_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_PREFETCH;
          end
        end
      end
      ST_PREFETCH: begin
        if (!laser_start_i) begin
          w_state_nxt = ST_DRAIN;
        end else if (r_pf_remain == '0) begin
          w_state_nxt         = ST_TRACK;
          w_prefetch_done_nxt = 1'b1;
        end else if (w_can_issue) begin
          w_issue         = 1'b1;
          w_pf_remain_nxt = r_pf_remain - SPACING_W'(1);
        end
      end
      ST_TRACK: begin
        if (!laser_start_i) begin
          w_state_nxt = ST_DRAIN;
        end else if (laser_vld_i) begin
          if (w_can_issue) begin
            w_issue = 1'b1;
          end else if (r_miss_cnt != '1) begin
            w_miss_cnt_nxt = r_miss_cnt + MISS_CNT_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (w_empty) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  rd_credit_cnt #(
    .MAX_CNT (MAX_OUTSTANDING)
  ) u_rd_credit_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (w_issue),
    .dec_i   (pre_laser_rd_vld_i),
    .cnt_o   (outstanding_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign pre_laser_rd_seq_o = r_rd_seq;
  assign prefetch_done_o    = r_prefetch_done;
  assign miss_cnt_o         = r_miss_cnt;
  assign second_track_en_o  = (r_state == ST_TRACK);
  assign busy_o             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pre_track_rd_ctrl.sv
// Self-checking bench for pre_track_rd_ctrl: vector table plus hand-written corner sequences.
module tb_pre_track_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] spacing = '0;
  logic        start = 1'b0;
  logic        zero = 1'b0;
  logic        lvld = 1'b0;
  logic        ready = 1'b0;
  logic        rvld = 1'b0;
  logic        rd_seq;
  logic        st_en;
  logic        pf_done;
  logic [4:0]  outst;
  logic [15:0] miss;
  logic        busy;

  int total = 0;
  int bad = 0;
  logic [15:0] cur_spacing = 16'd4;

  always #5 clk = ~clk;

  pre_track_rd_ctrl #(
    .TCQ             (0.1),
    .MAX_OUTSTANDING (16),
    .MISS_CNT_WIDTH  (16)
  ) dut (
    .clk_i                (clk),
    .rst_n_i              (rst_n),
    .light_spot_spacing_i (spacing),
    .laser_start_i        (start),
    .encode_zero_flag_i   (zero),
    .laser_vld_i          (lvld),
    .pre_laser_rd_ready_i (ready),
    .pre_laser_rd_vld_i   (rvld),
    .pre_laser_rd_seq_o   (rd_seq),
    .second_track_en_o    (st_en),
    .prefetch_done_o      (pf_done),
    .outstanding_o        (outst),
    .miss_cnt_o           (miss),
    .busy_o               (busy)
  );

  typedef struct {
    logic start, zero, lvld, ready, rvld;
    logic exp_seq, exp_done, exp_en, exp_busy;
    int   exp_out;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[8];

  function automatic vec_t mk(input logic s, input logic z, input logic lv, input logic rdy,
                              input logic rv, input logic eseq, input logic edone,
                              input logic een, input logic ebusy, input int eout);
    vec_t v;
    v.start = s; v.zero = z; v.lvld = lv; v.ready = rdy; v.rvld = rv;
    v.exp_seq = eseq; v.exp_done = edone; v.exp_en = een; v.exp_busy = ebusy;
    v.exp_out = eout;
    return v;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_out();
    vec_t e;
    e = sb_q.pop_front();
    cmp("rd_seq", int'(rd_seq), int'(e.exp_seq));
    cmp("prefetch_done", int'(pf_done), int'(e.exp_done));
    cmp("second_track_en", int'(st_en), int'(e.exp_en));
    cmp("busy", int'(busy), int'(e.exp_busy));
    cmp("outstanding", int'(outst), e.exp_out);
  endtask

  // Drive one cycle of stimulus and score the outputs it produces after the edge.
  task automatic cyc(input vec_t v);
    @(negedge clk);
    spacing = cur_spacing;
    start = v.start; zero = v.zero; lvld = v.lvld; ready = v.ready; rvld = v.rvld;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic run_table();
    cur_spacing = 16'd4;
    for (int i = 0; i < 8; i++) cyc(tbl[i]);
  endtask

  initial begin
    tbl[0] = mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    tbl[1] = mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    tbl[2] = mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 1);
    tbl[3] = mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 2);
    tbl[4] = mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 3);
    tbl[5] = mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 4);
    tbl[6] = mk(1, 0, 0, 1, 0, 0, 1, 1, 1, 4);
    tbl[7] = mk(1, 0, 0, 1, 0, 0, 0, 1, 1, 4);

    #12;
    cmp("reset_rd_seq", int'(rd_seq), 0);
    cmp("reset_busy", int'(busy), 0);
    cmp("reset_outstanding", int'(outst), 0);
    cmp("reset_miss", int'(miss), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Prefetch of 4 into tracking.
    run_table();

    // Three misses with ready low, then 1:1 requests again.
    repeat (3) cyc(mk(1, 0, 1, 0, 0, 0, 0, 1, 1, 4));
    cmp("miss_after_3", int'(miss), 3);
    cyc(mk(1, 0, 1, 1, 0, 1, 0, 1, 1, 5));
    cyc(mk(1, 0, 1, 1, 0, 1, 0, 1, 1, 6));
    cyc(mk(1, 0, 0, 1, 0, 0, 0, 1, 1, 6));
    cmp("miss_hold", int'(miss), 3);

    // Same-cycle issue and return at 5.
    cyc(mk(1, 0, 0, 1, 1, 0, 0, 1, 1, 5));
    cyc(mk(1, 0, 1, 1, 1, 1, 0, 1, 1, 5));

    // Drop start with 3 outstanding; start high in DRAIN is ignored.
    cyc(mk(1, 0, 0, 1, 1, 0, 0, 1, 1, 4));
    cyc(mk(1, 0, 0, 1, 1, 0, 0, 1, 1, 3));
    cyc(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 3));
    cyc(mk(1, 0, 1, 1, 1, 0, 0, 0, 1, 2));
    cyc(mk(1, 0, 1, 1, 1, 0, 0, 0, 1, 1));
    cyc(mk(1, 0, 1, 1, 1, 0, 0, 0, 1, 0));
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    cmp("miss_kept_in_idle", int'(miss), 3);

    // Spacing 20 against a 16-deep credit limit.
    cur_spacing = 16'd20;
    cyc(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    cmp("miss_cleared_on_start", int'(miss), 0);
    cyc(mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 20; i++)
      cyc(mk(1, 0, 0, 1, 0, logic'(i < 16), 0, 0, 1, (i < 16) ? i + 1 : 16));
    cyc(mk(1, 0, 0, 1, 1, 0, 0, 0, 1, 15));
    cyc(mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 16));
    cyc(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 16));

    // Asynchronous reset while still prefetching.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b0; zero = 1'b0; lvld = 1'b0; ready = 1'b0; rvld = 1'b0;
    #1;
    cmp("async_rst_rd_seq", int'(rd_seq), 0);
    cmp("async_rst_busy", int'(busy), 0);
    cmp("async_rst_outstanding", int'(outst), 0);
    cmp("async_rst_done", int'(pf_done), 0);
    cmp("async_rst_track_en", int'(st_en), 0);
    cmp("async_rst_miss", int'(miss), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    run_table();

    // Drain, then zero spacing goes straight to tracking.
    cyc(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 4));
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 3));
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 2));
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cur_spacing = 16'd0;
    cyc(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    cyc(mk(1, 1, 0, 1, 0, 0, 1, 1, 1, 0));
    cyc(mk(1, 0, 1, 1, 0, 1, 0, 1, 1, 1));

    cmp("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
